// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM type, default reset vector and alignment helper for the PC unit.
package pc_pkg;

    typedef enum logic [1:0] {BOOT, RUN, PEND} t_pc_state;

    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h3000_0000;

    function automatic logic is_aligned(input logic [63:0] addr, input int unsigned align_bits);
        return (addr & ((64'd1 << align_bits) - 64'd1)) == 64'd0;
    endfunction

endpackage

// File: rtl/pc_redirect_buffer.sv
// pc_redirect_buffer: single-entry holding register for a redirect that arrives during a stall.
module pc_redirect_buffer #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_ff @(posedge clk) begin
        if (!arstn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with sequential advance, trap/redirect handling and stall-buffered redirects.
module pc_unit import pc_pkg::*; #(
    parameter int          DATA_WIDTH   = 64,
    parameter logic [63:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          INSTR_BYTES  = 4,
    parameter int          ALIGN_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_stall,
    input  logic                  i_redirect_en,
    input  logic [DATA_WIDTH-1:0] i_redirect_pc,
    input  logic                  i_trap_en,
    input  logic [DATA_WIDTH-1:0] i_trap_pc,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_pc_plus,
    output logic                  o_pc_valid,
    output logic                  o_misaligned,
    output logic                  o_pending
);

    localparam logic [DATA_WIDTH-1:0] RST_PC     = RESET_VECTOR[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(INSTR_BYTES);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    t_pc_state             state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, buf_pc;
    logic                  mis_q, mis_d, buf_load, buf_clear, aligned, redir_ok;

    assign aligned  = is_aligned(64'(i_redirect_pc), ALIGN_BITS);
    assign redir_ok = i_redirect_en && aligned;

    // Trap beats redirect beats stall beats increment; BOOT ignores all inputs.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mis_d     = 1'b0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (i_trap_en) begin
            pc_d      = i_trap_pc & ~ALIGN_MASK;
            state_d   = RUN;
            buf_clear = 1'b1;
        end else begin
            mis_d = i_redirect_en && !aligned;
            if (redir_ok && i_stall) begin
                buf_load = 1'b1;
                state_d  = PEND;
            end else if (redir_ok) begin
                pc_d      = i_redirect_pc;
                state_d   = RUN;
                buf_clear = 1'b1;
            end else if (!i_stall) begin
                pc_d      = (state_q == PEND) ? buf_pc : o_pc_plus;
                state_d   = RUN;
                buf_clear = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q <= BOOT;
            pc_q    <= RST_PC;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
        end
    end

    pc_redirect_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk    (clk),
        .arstn  (arstn),
        .load_i (buf_load),
        .clear_i(buf_clear),
        .data_i (i_redirect_pc),
        .data_o (buf_pc),
        .valid_o(o_pending)
    );

    assign o_pc         = pc_q;
    assign o_pc_plus    = pc_q + STEP;
    assign o_pc_valid   = state_q != BOOT;
    assign o_misaligned = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and random stimulus against a behavioural PC model, plus a 32-bit wrap check.
module tb_pc_unit;

    logic        clk = 1'b0, arstn = 1'b0, stall = 1'b0, redir = 1'b0, trap = 1'b0;
    logic [63:0] rpc = '0, tpc = '0;
    logic [63:0] pc, pc_plus;
    logic        valid, mis, pend;
    logic        t32 = 1'b0;
    logic [31:0] tpc32 = '0, pc32, plus32;
    logic        valid32, mis32, pend32;
    int          n_vec = 0, n_err = 0;
    logic [63:0] m_pc = '0, m_buf = '0;
    bit          m_boot = 1'b1, m_pend = 1'b0, m_mis = 1'b0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .arstn(arstn), .i_stall(stall),
        .i_redirect_en(redir), .i_redirect_pc(rpc),
        .i_trap_en(trap), .i_trap_pc(tpc),
        .o_pc(pc), .o_pc_plus(pc_plus), .o_pc_valid(valid),
        .o_misaligned(mis), .o_pending(pend)
    );

    pc_unit #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .arstn(arstn), .i_stall(1'b0),
        .i_redirect_en(1'b0), .i_redirect_pc(32'h0),
        .i_trap_en(t32), .i_trap_pc(tpc32),
        .o_pc(pc32), .o_pc_plus(plus32), .o_pc_valid(valid32),
        .o_misaligned(mis32), .o_pending(pend32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference behaviour: what the PC unit must do at one rising edge given the held inputs.
    task automatic model();
        m_mis = 1'b0;
        if (!arstn) begin
            m_pc = 64'h3000_0000; m_boot = 1'b1; m_pend = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (trap) begin
            m_pc = tpc - tpc % 4; m_pend = 1'b0;
        end else begin
            if (redir && rpc % 4 != 0) m_mis = 1'b1;
            if (redir && rpc % 4 == 0 && stall) begin
                m_buf = rpc; m_pend = 1'b1;
            end else if (redir && rpc % 4 == 0) begin
                m_pc = rpc; m_pend = 1'b0;
            end else if (!stall) begin
                m_pc = m_pend ? m_buf : m_pc + 64'd4; m_pend = 1'b0;
            end
        end
    endtask

    task automatic apply(input logic a, input logic s, input logic r, input logic [63:0] rp,
                         input logic t, input logic [63:0] tp);
        arstn = a; stall = s; redir = r; rpc = rp; trap = t; tpc = tp;
        @(posedge clk);
        model();
        @(negedge clk);
        chk("pc", pc, m_pc);
        chk("pc_plus", pc_plus, m_pc + 64'd4);
        chk("valid", valid, 64'(!m_boot));
        chk("misaligned", mis, 64'(m_mis));
        chk("pending", pend, 64'(m_pend));
    endtask

    initial begin
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("rst_pc", pc, 64'h3000_0000);
        chk("rst_valid", valid, 0);
        chk("rst32_pc", pc32, 64'h3000_0000);
        apply(1, 0, 0, 0, 0, 0);
        chk("boot_pc", pc, 64'h3000_0000);
        chk("boot_valid", valid, 1);
        apply(1, 0, 0, 0, 0, 0);
        chk("inc1", pc, 64'h3000_0004);
        apply(1, 0, 0, 0, 0, 0);
        chk("inc2", pc, 64'h3000_0008);
        apply(1, 0, 1, 64'h8000_0010, 0, 0);
        chk("redir", pc, 64'h8000_0010);
        apply(1, 1, 1, 64'h4000_0020, 0, 0);
        chk("stall_pc", pc, 64'h8000_0010);
        chk("stall_pend", pend, 1);
        apply(1, 1, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0);
        chk("stall3_pc", pc, 64'h8000_0010);
        apply(1, 0, 0, 0, 0, 0);
        chk("release_pc", pc, 64'h4000_0020);
        chk("release_pend", pend, 0);
        apply(1, 0, 1, 64'h3000_0006, 0, 0);
        chk("mis_pulse", mis, 1);
        chk("mis_pc", pc, 64'h4000_0024);
        apply(1, 0, 0, 0, 0, 0);
        chk("mis_clear", mis, 0);
        chk("mis_pc2", pc, 64'h4000_0028);
        apply(1, 1, 1, 64'h5000_0000, 1, 64'h1003);
        chk("trap_pc", pc, 64'h1000);
        chk("trap_pend", pend, 0);
        apply(1, 1, 1, 64'h6000_0000, 0, 0);
        chk("pend_set", pend, 1);
        apply(0, 1, 0, 0, 0, 0);
        chk("pend_rst_pc", pc, 64'h3000_0000);
        chk("pend_rst_pend", pend, 0);
        chk("pend_rst_valid", valid, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wrap64_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap64_plus", pc_plus, 0);
        apply(1, 0, 0, 0, 0, 0);
        chk("wrap64_next", pc, 0);
        for (int i = 0; i < 500; i++) begin
            logic [63:0] r;
            r = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) r = r & ~64'h3;
            apply($urandom_range(0, 49) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, r,
                  $urandom_range(0, 11) == 0, {$urandom, $urandom});
        end
        apply(0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        t32 = 1'b1; tpc32 = 32'hFFFF_FFFC;
        apply(1, 0, 0, 0, 0, 0);
        chk("wrap32_pc", pc32, 64'hFFFF_FFFC);
        chk("wrap32_plus", plus32, 0);
        t32 = 1'b0;
        apply(1, 0, 0, 0, 0, 0);
        chk("wrap32_next", pc32, 0);
        chk("wrap32_valid", valid32, 1);
        chk("wrap32_flags", {mis32, pend32}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
